brew_scheduler: RTL
===================

# brew_scheduler

Sequences the coffee machine's shared actuators (grinder, heater, pump, milk valve, frother) for queued drink orders. Orders arrive from the button/menu front end through a valid/ready port and are buffered in a small FIFO. Each order is then executed as a fixed per-drink step program, timed by an internal tick divider. The `led` vector drives the actuator indicators; `step` feeds the state 7-segment decoder.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per step tick; must be ≥ 2.
- `QUEUE_DEPTH`, default 4: order FIFO depth; power of two, 2..16.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; clears all state.
- `order_valid` in 1: order request.
- `order_type` in 2: 0 = expreso, 1 = latte, 2 = capuchino, 3 = invalid.
- `order_ready` out 1: FIFO not full (registered count < QUEUE_DEPTH).
- `abort` in 1: cancel the drink in progress.
- `busy` out 1: state ≠ IDLE.
- `step` out 3: IDLE=0, GRIND=1, HEAT=2, PUMP=3, MILK=4, FOAM=5, DONE=6.
- `cur_type` out 2: type of the drink in progress; holds its last value in IDLE.
- `led` out 5: actuator one-hot; [0] grind, [1] heat, [2] pump, [3] milk, [4] foam.
- `queue_count` out $clog2(QUEUE_DEPTH)+1: number of orders in the FIFO.
- `done` out 1: one-cycle pulse when a drink completes.
- `reject` out 1: one-cycle pulse, registered, when an invalid order (type 3) is offered while order_ready=1.

## Operation
- **Acceptance:** push when order_valid && order_ready && order_type≠3. Type 3 is dropped and pulses `reject` next cycle. Offers while not ready are ignored; no reject.
- **Dispatch:** in IDLE with queue_count>0, pop the head, load `cur_type`, and enter GRIND next cycle. Push and pop in the same cycle leave the count unchanged. `order_ready` uses the registered count, so a push while full is refused even if a pop occurs that cycle.
- **Step programs** (ticks per state):
  - expreso: GRIND 2, HEAT 3, PUMP 3, DONE 1.
  - latte: GRIND 2, HEAT 3, PUMP 3, MILK 4, DONE 1.
  - capuchino: GRIND 2, HEAT 3, PUMP 3, MILK 2, FOAM 3, DONE 1.
  - After PUMP, expreso goes to DONE; latte/capuchino go to MILK. After MILK, latte goes to DONE; capuchino goes to FOAM.
- **led** is decoded from the state: GRIND 00001, HEAT 00010, PUMP 00100, MILK 01000, FOAM 10000, DONE 11111, IDLE 00000.
- **Divider:** held at 0 in IDLE. In other states it counts 0..TICK_DIV-1 and wraps; tick fires on the TICK_DIV-1 cycle. A per-state tick counter is cleared on every state change. On a tick with tick counter = duration-1, advance the state.
- **Completion:** DONE→IDLE raises `done` during the first IDLE cycle. The next queued order is popped in that same cycle.
- **Abort:** in any non-IDLE state, the next cycle is IDLE with led=0 and divider/tick counter cleared; no `done`, queue untouched. Abort has priority over tick. Abort in IDLE has no effect.
- **Reset values:** state IDLE, step 0, led 0, cur_type 0, busy 0, done 0, reject 0, queue_count 0, order_ready 1, FIFO pointers 0.

## Timing
- Order accepted in cycle N with the FIFO empty and state IDLE: count=1 at N+1, popped at N+1, state=GRIND at N+2.
- Each state lasts exactly duration×TICK_DIV cycles.
- Drink latency from entering GRIND to the `done` cycle:
  - expreso: 9×TICK_DIV.
  - latte: 13×TICK_DIV.
  - capuchino: 14×TICK_DIV.
- Back-to-back orders: GRIND of order k+1 starts one cycle after the `done` cycle of order k.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset asserted mid-drink: all state is cleared at the next edge, and the FIFO contents are lost.

## Test plan
- **Expreso** (TICK_DIV=4): type 0 accepted at cycle 0 → state GRIND at cycle 2; led 00001 for cycles 2–9, 00010 for 10–21, 00100 for 22–33, 11111 for 34–37; `done`=1 at cycle 38 only.
- **Capuchino then latte queued**, each offered once on consecutive cycles, from IDLE with TICK_DIV=4: capuchino `done` at cycle 58. Latte GRIND at cycle 59, its `done` at 111. `step` sequence 1,2,3,4,5,6 then 1,2,3,4,6.
- **Full queue** (QUEUE_DEPTH=4): offer 6 valid orders on cycles 0–5 from reset → order_ready falls at cycle 5 and the 6th is not accepted. queue_count peaks at 4.
- **Invalid type:** order_type=3 with order_valid=1 for one cycle → `reject` high one cycle; queue_count and state unchanged.
- **Abort during MILK** of a latte with one order queued → IDLE next cycle, led 00000, no `done`; the queued order is in GRIND two cycles after abort.
- **Reset mid-PUMP** (reset=0 for one cycle) → all outputs at reset values on the next cycle; queue_count 0.

Source files
------------

// File: rtl/brew_scheduler.sv
// Coffee machine actuator sequencer: an order FIFO feeding a per-drink step
// program, with each step timed in ticks of an internal clock divider.
module brew_scheduler #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           order_valid,
  input  logic [1:0]                     order_type,
  output logic                           order_ready,
  input  logic                           abort,
  output logic                           busy,
  output logic [2:0]                     step,
  output logic [1:0]                     cur_type,
  output logic [4:0]                     led,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           done,
  output logic                           reject
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(TICK_DIV);

  localparam logic [1:0] T_EXPRESO   = 2'd0;
  localparam logic [1:0] T_CAPUCHINO = 2'd2;
  localparam logic [1:0] T_INVALID   = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRIND = 3'd1,
    HEAT  = 3'd2,
    PUMP  = 3'd3,
    MILK  = 3'd4,
    FOAM  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic [2:0]      tick_cnt_q;
  logic [2:0]      dur;
  logic            tick;
  logic            adv;
  logic            push;
  logic            pop;
  logic [1:0]      cur_type_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [1:0]      mem [QUEUE_DEPTH];

  assign order_ready = (count_q < CW'(QUEUE_DEPTH));
  assign push        = order_valid && order_ready && (order_type != T_INVALID);
  assign busy        = (state_q != IDLE);
  assign step        = state_q;
  assign cur_type    = cur_type_q;
  assign queue_count = count_q;

  // Ticks spent in the current state before advancing.
  always_comb begin
    dur = 3'd1;
    case (state_q)
      GRIND:   dur = 3'd2;
      HEAT:    dur = 3'd3;
      PUMP:    dur = 3'd3;
      MILK:    dur = (cur_type_q == T_CAPUCHINO) ? 3'd2 : 3'd4;
      FOAM:    dur = 3'd3;
      DONE:    dur = 3'd1;
      default: dur = 3'd1;
    endcase
  end

  assign tick = (state_q != IDLE) && (div_q == DW'(TICK_DIV - 1));
  assign adv  = tick && (tick_cnt_q == (dur - 3'd1));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = GRIND;
        end
      end
      GRIND:   if (adv) state_d = HEAT;
      HEAT:    if (adv) state_d = PUMP;
      PUMP:    if (adv) state_d = (cur_type_q == T_EXPRESO) ? DONE : MILK;
      MILK:    if (adv) state_d = (cur_type_q == T_CAPUCHINO) ? FOAM : DONE;
      FOAM:    if (adv) state_d = DONE;
      DONE:    if (adv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    led = '0;
    case (state_q)
      GRIND:   led = 5'b00001;
      HEAT:    led = 5'b00010;
      PUMP:    led = 5'b00100;
      MILK:    led = 5'b01000;
      FOAM:    led = 5'b10000;
      DONE:    led = 5'b11111;
      default: led = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      tick_cnt_q <= '0;
      cur_type_q <= '0;
      done       <= 1'b0;
      reject     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;

      // Divider restarts on entry from IDLE and on any return to IDLE.
      if ((state_q == IDLE) || (state_d == IDLE) || tick) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + DW'(1);
      end

      if (state_d != state_q) begin
        tick_cnt_q <= '0;
      end else if (tick) begin
        tick_cnt_q <= tick_cnt_q + 3'd1;
      end

      done   <= (state_q == DONE) && adv && !abort;
      reject <= order_valid && order_ready && (order_type == T_INVALID);

      if (pop) begin
        cur_type_q <= mem[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= order_type;
    end
  end

endmodule
